// File: rtl/fv_obi_mem_responder.sv
// ----------------------------------------------------------------------------
//  fv_obi_mem_responder
//  OBI subordinate: word-addressed memory with an in-order, fixed-latency
//  response FIFO and grant/response stall inputs for back-pressure.
//  Revision: 1.0
// ----------------------------------------------------------------------------
`default_nettype none

module fv_obi_mem_responder #(
   parameter int ADDR_WIDTH      = 32,
   parameter int DATA_WIDTH      = 32,
   parameter int MEM_WORDS       = 256,
   parameter int MAX_OUTSTANDING = 2,
   parameter int LATENCY         = 1
) (
   input  logic                    clk_i,
   input  logic                    rst_i,
   input  logic                    req_i,
   output logic                    gnt_o,
   input  logic [ADDR_WIDTH-1:0]   addr_i,
   input  logic                    we_i,
   input  logic [DATA_WIDTH/8-1:0] be_i,
   input  logic [DATA_WIDTH-1:0]   wdata_i,
   output logic                    rvalid_o,
   output logic [DATA_WIDTH-1:0]   rdata_o,
   output logic                    err_o,
   input  logic                    gnt_stall_i,
   input  logic                    rvalid_stall_i,
   output logic [3:0]              outstanding_o
);

   localparam int         NB       = DATA_WIDTH / 8;
   localparam int         OFF_W    = $clog2(NB);
   localparam int         IDX_W    = $clog2(MEM_WORDS);
   localparam int         HI_LSB   = OFF_W + IDX_W;
   localparam logic [3:0] MAX_CNT  = 4'(MAX_OUTSTANDING);
   localparam logic [3:0] LAT_CNT  = 4'(LATENCY);
   localparam logic [3:0] LAT_ELIG = 4'(LATENCY - 1);

   logic [DATA_WIDTH-1:0] mem_q [MEM_WORDS];

   logic [DATA_WIDTH-1:0] fifo_rdata_q [MAX_OUTSTANDING];
   logic [DATA_WIDTH-1:0] fifo_rdata_d [MAX_OUTSTANDING];
   logic                  fifo_err_q   [MAX_OUTSTANDING];
   logic                  fifo_err_d   [MAX_OUTSTANDING];
   logic [3:0]            fifo_age_q   [MAX_OUTSTANDING];
   logic [3:0]            fifo_age_d   [MAX_OUTSTANDING];

   logic [3:0]            count_q, count_d;
   logic                  rvalid_q, rvalid_d;
   logic [DATA_WIDTH-1:0] rdata_q, rdata_d;
   logic                  err_q, err_d;

   logic [IDX_W-1:0]      idx;
   logic                  out_of_range;
   logic                  accept;
   logic                  mem_we;
   logic                  pop;
   logic [3:0]            push_idx;

   assign gnt_o        = !rst_i && !gnt_stall_i && (count_q < MAX_CNT);
   assign accept       = req_i && gnt_o;
   assign idx          = addr_i[OFF_W +: IDX_W];
   assign out_of_range = (addr_i >> HI_LSB) != '0;
   assign mem_we       = accept && we_i && !out_of_range;

   // Head age is the value stored before this edge, so a fresh push is never
   // eligible on its own push edge.
   assign pop = (count_q != 4'd0) && (fifo_age_q[0] >= LAT_ELIG) && !rvalid_stall_i;

   always_comb begin
      count_d  = count_q + {3'b000, accept} - {3'b000, pop};
      rvalid_d = pop;
      rdata_d  = rdata_q;
      err_d    = err_q;
      push_idx = count_q - {3'b000, pop};
      if (pop) begin
         rdata_d = fifo_rdata_q[0];
         err_d   = fifo_err_q[0];
      end
      for (int i = 0; i < MAX_OUTSTANDING; i++) begin
         if (pop) begin
            fifo_rdata_d[i] = fifo_rdata_q[(i + 1) % MAX_OUTSTANDING];
            fifo_err_d[i]   = fifo_err_q[(i + 1) % MAX_OUTSTANDING];
            fifo_age_d[i]   = fifo_age_q[(i + 1) % MAX_OUTSTANDING];
         end else begin
            fifo_rdata_d[i] = fifo_rdata_q[i];
            fifo_err_d[i]   = fifo_err_q[i];
            fifo_age_d[i]   = fifo_age_q[i];
         end
         if (fifo_age_d[i] != LAT_CNT) begin
            fifo_age_d[i] = fifo_age_d[i] + 4'd1;
         end
         if (accept && (push_idx == 4'(i))) begin
            fifo_rdata_d[i] = (we_i || out_of_range) ? '0 : mem_q[idx];
            fifo_err_d[i]   = out_of_range;
            fifo_age_d[i]   = 4'd0;
         end
      end
   end

   always_ff @(posedge clk_i) begin
      if (rst_i) begin
         count_q  <= 4'd0;
         rvalid_q <= 1'b0;
         rdata_q  <= '0;
         err_q    <= 1'b0;
      end else begin
         count_q  <= count_d;
         rvalid_q <= rvalid_d;
         rdata_q  <= rdata_d;
         err_q    <= err_d;
      end
   end

   // Entries beyond count_q are don't-care, so the FIFO storage needs no reset.
   always_ff @(posedge clk_i) begin
      fifo_rdata_q <= fifo_rdata_d;
      fifo_err_q   <= fifo_err_d;
      fifo_age_q   <= fifo_age_d;
   end

   always_ff @(posedge clk_i) begin
      if (mem_we) begin
         for (int k = 0; k < NB; k++) begin
            if (be_i[k]) begin
               mem_q[idx][8*k +: 8] <= wdata_i[8*k +: 8];
            end
         end
      end
   end

   assign rvalid_o      = rvalid_q;
   assign rdata_o       = rdata_q;
   assign err_o         = err_q;
   assign outstanding_o = count_q;

endmodule

`default_nettype wire

// File: tb/tb_fv_obi_mem_responder.sv
// ----------------------------------------------------------------------------
//  tb_fv_obi_mem_responder
//  Randomized and directed bench against a transaction-level queue model.
//  Revision: 1.0
// ----------------------------------------------------------------------------
`default_nettype none

module tb_fv_obi_mem_responder;

   localparam int MW  = 256;
   localparam int MO  = 2;
   localparam int LAT = 3;

   logic        clk = 1'b0;
   logic        rst, req, we, gstall, rstall;
   logic [31:0] addr, wdata;
   logic [3:0]  be;
   logic        gnt, rvalid, err;
   logic [31:0] rdata;
   logic [3:0]  outst;

   fv_obi_mem_responder #(
      .ADDR_WIDTH(32), .DATA_WIDTH(32), .MEM_WORDS(MW),
      .MAX_OUTSTANDING(MO), .LATENCY(LAT)
   ) dut (
      .clk_i(clk), .rst_i(rst), .req_i(req), .gnt_o(gnt), .addr_i(addr),
      .we_i(we), .be_i(be), .wdata_i(wdata), .rvalid_o(rvalid), .rdata_o(rdata),
      .err_o(err), .gnt_stall_i(gstall), .rvalid_stall_i(rstall),
      .outstanding_o(outst)
   );

   always #5 clk = ~clk;

   typedef struct packed {
      logic [31:0] data;
      logic        err;
      int          edge_i;
   } ent_t;

   ent_t        q[$];
   logic [31:0] mdl_mem [MW];
   int          edge_n, checks, failures;
   logic        obs_gnt, exp_gnt, exp_rvalid, exp_err;
   logic [31:0] exp_rdata;
   logic [3:0]  exp_cnt, obs_cnt;

   // Advance one clock and update the model: a transaction accepted at edge a
   // may respond at edge a+LAT or later, one per edge, in order.
   task automatic tick();
      ent_t e;
      int   w;
      @(negedge clk);
      obs_gnt = gnt;
      obs_cnt = outst;
      exp_gnt = !rst && !gstall && (q.size() < MO);
      if (rst) begin
         q.delete();
         exp_rvalid = 1'b0; exp_err = 1'b0; exp_rdata = '0;
      end else begin
         exp_rvalid = 1'b0;
         if (q.size() > 0 && !rstall) begin
            if (q[0].edge_i + LAT <= edge_n) begin
               exp_rvalid = 1'b1;
               exp_rdata  = q[0].data;
               exp_err    = q[0].err;
               void'(q.pop_front());
            end
         end
         if (req && exp_gnt) begin
            w        = int'(addr >> 2);
            e.err    = (addr >= 32'(MW * 4));
            e.edge_i = edge_n;
            e.data   = (we || e.err) ? 32'h0 : mdl_mem[w % MW];
            if (we && !e.err)
               for (int k = 0; k < 4; k++)
                  if (be[k]) mdl_mem[w][8*k +: 8] = wdata[8*k +: 8];
            q.push_back(e);
         end
      end
      exp_cnt = 4'(q.size());
      @(posedge clk);
      #1;
      edge_n++;
   endtask

   task automatic test_reset();
      rst = 1'b1; req = 1'b1; we = 1'b1; addr = 32'h0; be = 4'hf; wdata = $urandom;
      for (int i = 0; i < 3; i++) begin
         tick();
         checks++;
         if ({obs_gnt, rvalid, err, rdata, outst} !== 38'h0) begin
            failures++;
            $display("FAIL reset: got gnt=%b rv=%b err=%b rdata=%h cnt=%0d, required all zero",
                     obs_gnt, rvalid, err, rdata, outst);
         end
      end
      rst = 1'b0; req = 1'b0;
   endtask

   task automatic test_fill();
      for (int i = 0; i < MW; i++) begin
         req = 1'b1; we = 1'b1; addr = 32'(i * 4); be = 4'hf; wdata = $urandom;
         for (int t = 0; t < 20; t++) begin
            tick();
            checks++;
            if ({obs_gnt, rvalid, err, rdata, outst} !== {exp_gnt, exp_rvalid, exp_err, exp_rdata, exp_cnt}) begin
               failures++;
               $display("FAIL fill e=%0d: got gnt=%b rv=%b err=%b rdata=%h cnt=%0d, required gnt=%b rv=%b err=%b rdata=%h cnt=%0d",
                        edge_n, obs_gnt, rvalid, err, rdata, outst, exp_gnt, exp_rvalid, exp_err, exp_rdata, exp_cnt);
            end
            if (exp_gnt) break;
         end
      end
      req = 1'b0;
      for (int t = 0; t < 20 && q.size() != 0; t++) tick();
   endtask

   task automatic test_write_read();
      logic [31:0] got[$];
      logic        we_t[4] = '{1'b1, 1'b0, 1'b1, 1'b0};
      logic [3:0]  be_t[4] = '{4'hf, 4'hf, 4'b0010, 4'hf};
      logic [31:0] wd_t[4] = '{32'hDEADBEEF, 32'h0, 32'h0000AB00, 32'h0};
      int n = 0;
      for (int t = 0; t < 40; t++) begin
         if (n < 4) begin
            req = 1'b1; we = we_t[n]; addr = 32'h10; be = be_t[n]; wdata = wd_t[n];
         end else req = 1'b0;
         tick();
         checks++;
         if ({obs_gnt, rvalid, err, rdata, outst} !== {exp_gnt, exp_rvalid, exp_err, exp_rdata, exp_cnt}) begin
            failures++;
            $display("FAIL write_read e=%0d: got gnt=%b rv=%b err=%b rdata=%h cnt=%0d, required gnt=%b rv=%b err=%b rdata=%h cnt=%0d",
                     edge_n, obs_gnt, rvalid, err, rdata, outst, exp_gnt, exp_rvalid, exp_err, exp_rdata, exp_cnt);
         end
         if (rvalid) got.push_back(rdata);
         if (req && exp_gnt) n++;
         if (n == 4 && q.size() == 0) break;
      end
      req = 1'b0;
      checks++;
      if (got.size() != 4) begin
         failures++;
         $display("FAIL write_read_count: got %0d responses, required 4", got.size());
      end else begin
         checks++;
         if ({got[0], got[1], got[2], got[3]} !== {32'h0, 32'hDEADBEEF, 32'h0, 32'hDEADABEF}) begin
            failures++;
            $display("FAIL write_read_data: got %h %h %h %h, required 0 deadbeef 0 deadabef",
                     got[0], got[1], got[2], got[3]);
         end
      end
   endtask

   task automatic test_full();
      logic       g_t[6] = '{1'b1, 1'b1, 1'b0, 1'b0, 1'b1, 1'b1};
      logic [3:0] c_t[6] = '{4'd0, 4'd1, 4'd2, 4'd2, 4'd1, 4'd0};
      logic       r_t[6] = '{1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0};
      for (int i = 0; i < 6; i++) begin
         req = (i < 3); we = 1'b0; addr = 32'($urandom_range(0, MW - 1) * 4); be = 4'hf;
         tick();
         checks++;
         if ({obs_gnt, obs_cnt, rvalid} !== {g_t[i], c_t[i], r_t[i]}) begin
            failures++;
            $display("FAIL full step %0d: got gnt=%b cnt=%0d rv=%b, required gnt=%b cnt=%0d rv=%b",
                     i, obs_gnt, obs_cnt, rvalid, g_t[i], c_t[i], r_t[i]);
         end
         checks++;
         if ({rdata, err, outst} !== {exp_rdata, exp_err, exp_cnt}) begin
            failures++;
            $display("FAIL full_model step %0d: got rdata=%h err=%b cnt=%0d, required rdata=%h err=%b cnt=%0d",
                     i, rdata, err, outst, exp_rdata, exp_err, exp_cnt);
         end
      end
      req = 1'b0;
   endtask

   task automatic test_error();
      logic [31:0] gd[$];
      logic        ge[$];
      logic [31:0] w0;
      logic        we_t[3] = '{1'b0, 1'b1, 1'b0};
      logic [31:0] ad_t[3] = '{32'h400, 32'h400, 32'h0};
      int n = 0;
      w0 = mdl_mem[0];
      for (int t = 0; t < 40; t++) begin
         if (n < 3) begin
            req = 1'b1; we = we_t[n]; addr = ad_t[n]; be = 4'hf; wdata = ~w0;
         end else req = 1'b0;
         tick();
         checks++;
         if ({obs_gnt, rvalid, err, rdata, outst} !== {exp_gnt, exp_rvalid, exp_err, exp_rdata, exp_cnt}) begin
            failures++;
            $display("FAIL error e=%0d: got gnt=%b rv=%b err=%b rdata=%h cnt=%0d, required gnt=%b rv=%b err=%b rdata=%h cnt=%0d",
                     edge_n, obs_gnt, rvalid, err, rdata, outst, exp_gnt, exp_rvalid, exp_err, exp_rdata, exp_cnt);
         end
         if (rvalid) begin gd.push_back(rdata); ge.push_back(err); end
         if (req && exp_gnt) n++;
         if (n == 3 && q.size() == 0) break;
      end
      req = 1'b0;
      checks++;
      if (gd.size() != 3) begin
         failures++;
         $display("FAIL error_count: got %0d responses, required 3", gd.size());
      end else begin
         checks++;
         if ({ge[0], gd[0], ge[1], gd[1], ge[2], gd[2]} !== {1'b1, 32'h0, 1'b1, 32'h0, 1'b0, w0}) begin
            failures++;
            $display("FAIL error_resp: got e%b/%h e%b/%h e%b/%h, required e1/0 e1/0 e0/%h",
                     ge[0], gd[0], ge[1], gd[1], ge[2], gd[2], w0);
         end
      end
   endtask

   task automatic test_stalls();
      int          a0, a1;
      logic [31:0] d0, d1;
      logic        seen;
      a0 = $urandom_range(0, MW - 1); a1 = $urandom_range(0, MW - 1);
      d0 = mdl_mem[a0]; d1 = mdl_mem[a1];
      rstall = 1'b1;
      for (int i = 0; i < 7; i++) begin
         req = (i < 2); we = 1'b0; addr = 32'(((i == 0) ? a0 : a1) * 4) | 32'($urandom_range(0, 3));
         be = 4'($urandom);
         tick();
         checks++;
         if ({obs_gnt, rvalid, outst} !== {exp_gnt, 1'b0, exp_cnt}) begin
            failures++;
            $display("FAIL stall_hold step %0d: got gnt=%b rv=%b cnt=%0d, required gnt=%b rv=0 cnt=%0d",
                     i, obs_gnt, rvalid, outst, exp_gnt, exp_cnt);
         end
      end
      req = 1'b0; rstall = 1'b0;
      for (int i = 0; i < 2; i++) begin
         tick();
         checks++;
         if ({rvalid, err, rdata} !== {1'b1, 1'b0, (i == 0) ? d0 : d1}) begin
            failures++;
            $display("FAIL stall_release %0d: got rv=%b err=%b rdata=%h, required rv=1 err=0 rdata=%h",
                     i, rvalid, err, rdata, (i == 0) ? d0 : d1);
         end
      end
      gstall = 1'b1; req = 1'b1; we = 1'b1; addr = 32'(a0 * 4); be = 4'hf; wdata = ~d0;
      for (int i = 0; i < 3; i++) begin
         tick();
         checks++;
         if ({obs_gnt, outst} !== {1'b0, 4'd0}) begin
            failures++;
            $display("FAIL gnt_stall %0d: got gnt=%b cnt=%0d, required gnt=0 cnt=0", i, obs_gnt, outst);
         end
      end
      gstall = 1'b0; we = 1'b0;
      tick();
      req = 1'b0;
      seen = 1'b0;
      for (int t = 0; t < 10 && !seen; t++) begin
         tick();
         if (rvalid) begin
            seen = 1'b1;
            checks++;
            if (rdata !== d0) begin
               failures++;
               $display("FAIL gnt_stall_mem: got rdata=%h, required %h", rdata, d0);
            end
         end
      end
      checks++;
      if (!seen) begin
         failures++;
         $display("FAIL gnt_stall_timeout: got no rvalid, required a response");
      end
   endtask

   task automatic test_reset_mid();
      logic seen;
      logic        rq_t[4] = '{1'b1, 1'b0, 1'b0, 1'b1};
      logic        we_t[4] = '{1'b1, 1'b0, 1'b0, 1'b0};
      for (int i = 0; i < 4; i++) begin
         req = rq_t[i]; we = we_t[i]; addr = 32'h20; be = 4'hf; wdata = 32'h55AA55AA;
         tick();
         checks++;
         if ({obs_gnt, rvalid, err, rdata, outst} !== {exp_gnt, exp_rvalid, exp_err, exp_rdata, exp_cnt}) begin
            failures++;
            $display("FAIL reset_mid e=%0d: got gnt=%b rv=%b err=%b rdata=%h cnt=%0d, required gnt=%b rv=%b err=%b rdata=%h cnt=%0d",
                     edge_n, obs_gnt, rvalid, err, rdata, outst, exp_gnt, exp_rvalid, exp_err, exp_rdata, exp_cnt);
         end
      end
      req = 1'b0; rst = 1'b1;
      tick();
      checks++;
      if ({rvalid, err, rdata, outst} !== 38'h0) begin
         failures++;
         $display("FAIL reset_mid_out: got rv=%b err=%b rdata=%h cnt=%0d, required all zero", rvalid, err, rdata, outst);
      end
      rst = 1'b0;
      for (int i = 0; i < 6; i++) begin
         tick();
         checks++;
         if ({rvalid, outst} !== 5'h0) begin
            failures++;
            $display("FAIL reset_mid_drop %0d: got rv=%b cnt=%0d, required rv=0 cnt=0", i, rvalid, outst);
         end
      end
      req = 1'b1; we = 1'b0; addr = 32'h20;
      tick();
      req = 1'b0;
      seen = 1'b0;
      for (int t = 0; t < 10 && !seen; t++) begin
         tick();
         if (rvalid) begin
            seen = 1'b1;
            checks++;
            if (rdata !== 32'h55AA55AA) begin
               failures++;
               $display("FAIL reset_mid_mem: got rdata=%h, required 55aa55aa", rdata);
            end
         end
      end
      checks++;
      if (!seen) begin
         failures++;
         $display("FAIL reset_mid_timeout: got no rvalid, required a response");
      end
   endtask

   task automatic test_random();
      for (int i = 0; i < 400; i++) begin
         rst    = ($urandom_range(0, 63) == 0);
         req    = ($urandom_range(0, 9) < 7);
         we     = $urandom_range(0, 1) == 1;
         be     = 4'($urandom);
         wdata  = $urandom;
         gstall = ($urandom_range(0, 7) == 0);
         rstall = ($urandom_range(0, 3) == 0);
         if ($urandom_range(0, 9) == 0) addr = $urandom | (32'h1 << $urandom_range(10, 31));
         else addr = {22'h0, 8'($urandom_range(0, MW - 1)), 2'($urandom)};
         tick();
         checks++;
         if ({obs_gnt, rvalid, err, rdata, outst} !== {exp_gnt, exp_rvalid, exp_err, exp_rdata, exp_cnt}) begin
            failures++;
            $display("FAIL random e=%0d: got gnt=%b rv=%b err=%b rdata=%h cnt=%0d, required gnt=%b rv=%b err=%b rdata=%h cnt=%0d",
                     edge_n, obs_gnt, rvalid, err, rdata, outst, exp_gnt, exp_rvalid, exp_err, exp_rdata, exp_cnt);
         end
      end
      rst = 1'b0; req = 1'b0; gstall = 1'b0; rstall = 1'b0;
   endtask

   initial begin
      checks = 0; failures = 0; edge_n = 0;
      rst = 1'b1; req = 1'b0; we = 1'b0; addr = '0; be = '0; wdata = '0;
      gstall = 1'b0; rstall = 1'b0;
      exp_rdata = '0; exp_err = 1'b0; exp_rvalid = 1'b0; exp_gnt = 1'b0; exp_cnt = '0;
      test_reset();
      test_fill();
      test_write_read();
      test_full();
      test_error();
      test_stalls();
      test_reset_mid();
      test_random();
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

   initial begin
      #1000000;
      $display("FAIL watchdog: got no completion by 1ms, required completion");
      $fatal(1, "watchdog expired");
   end

endmodule

`default_nettype wire
